// File: rtl/uart_tx_wb_if.sv
// uart_tx_wb_if: pipelined Wishbone slave signals for the UART transmitter
interface uart_tx_wb_if;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic        wb_we_i;
  logic [31:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [3:0]  wb_sel_i;
  logic        wb_stall_o;
  logic        wb_ack_o;
  logic        wb_err_o;
  logic [31:0] wb_dat_o;
  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
    input  wb_stall_o, wb_ack_o, wb_err_o, wb_dat_o
  );
  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
    output wb_stall_o, wb_ack_o, wb_err_o, wb_dat_o
  );
endinterface

// File: rtl/uart_tx_wb.sv
// uart_tx_wb: Wishbone-mapped 8N1 UART transmitter with FIFO and programmable divisor
module uart_tx_wb #(
  parameter logic [31:0] BASE_ADR   = 32'h0000_2020,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET  = 16'd433
) (
  input  logic         wb_clk_i,
  input  logic         wb_rst_i,
  uart_tx_wb_if.slave  wb,
  output logic         tx_o,
  output logic         irq_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t      state_q, state_d;
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  logic [7:0]  mem_q [FIFO_DEPTH];
  logic [7:0]  sh_q, sh_d, status;
  logic [2:0]  bit_q, bit_d;
  logic [15:0] baud_q, baud_d, div_q, div_d;
  logic [1:0]  ctrl_q, ctrl_d;
  logic        ack_q, ack_d, err_q, err_d, irq_q, irq_d;
  logic [31:0] dat_q, dat_d, off, rdat;
  logic        req, in_range, wreg, wr_tx, full, empty, busy, push, pop, start_ok;
  logic        unused;
  assign unused = ^{off[1:0], wb.wb_dat_i[31:16], wb.wb_sel_i[3:2]};
  always_comb begin
    off      = wb.wb_adr_i - BASE_ADR;
    req      = wb.wb_cyc_i & wb.wb_stb_i;
    in_range = off[31:4] == '0;
    wreg     = req & wb.wb_we_i & in_range;
    wr_tx    = wreg & (off[3:2] == 2'd0) & wb.wb_sel_i[0];
    full     = cnt_q == FULL_CNT;
    empty    = cnt_q == '0;
    busy     = state_q != IDLE;
    status   = {4'(cnt_q), 1'b0, busy, empty, full};
    push     = wr_tx & ~full;
    err_d    = req & (~in_range | (wr_tx & full));
    ack_d    = req & ~err_d;
    rdat     = off[3:2] == 2'd1 ? {24'b0, status} :
               off[3:2] == 2'd2 ? {16'b0, div_q} :
               off[3:2] == 2'd3 ? {30'b0, ctrl_q} : '0;
    dat_d    = (ack_d & ~wb.wb_we_i) ? rdat : '0;
    div_d    = {(wreg & off[3:2] == 2'd2 & wb.wb_sel_i[1]) ? wb.wb_dat_i[15:8] : div_q[15:8],
                (wreg & off[3:2] == 2'd2 & wb.wb_sel_i[0]) ? wb.wb_dat_i[7:0]  : div_q[7:0]};
    ctrl_d   = (wreg & off[3:2] == 2'd3 & wb.wb_sel_i[0]) ? wb.wb_dat_i[1:0] : ctrl_q;
    irq_d    = ctrl_q[1] & ~busy & empty;
    start_ok = ctrl_q[0] & ~empty;
    state_d  = state_q;
    baud_d   = baud_q;
    sh_d     = sh_q;
    bit_d    = bit_q;
    pop      = 1'b0;
    if (state_q == IDLE) begin
      if (start_ok) begin
        pop     = 1'b1;
        sh_d    = mem_q[rd_q];
        baud_d  = div_q;
        state_d = START;
      end
    end else if (baud_q != '0) begin
      baud_d = baud_q - 16'd1;
    end else begin
      baud_d = div_q;
      case (state_q)
        START: begin
          state_d = DATA;
          bit_d   = 3'd0;
        end
        DATA: begin
          sh_d    = sh_q >> 1;
          bit_d   = bit_q + 3'd1;
          state_d = bit_q == 3'd7 ? STOP : DATA;
        end
        default: begin
          pop     = start_ok;
          sh_d    = start_ok ? mem_q[rd_q] : sh_q;
          state_d = start_ok ? START : IDLE;
        end
      endcase
    end
    wr_d  = push ? wr_q + AW'(1) : wr_q;
    rd_d  = pop ? rd_q + AW'(1) : rd_q;
    cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
  end
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      sh_q    <= '0;
      bit_q   <= '0;
      baud_q  <= '0;
      div_q   <= DIV_RESET;
      ctrl_q  <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      dat_q   <= '0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      bit_q   <= bit_d;
      baud_q  <= baud_d;
      div_q   <= div_d;
      ctrl_q  <= ctrl_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      dat_q   <= dat_d;
      irq_q   <= irq_d;
    end
  end
  always_ff @(posedge wb_clk_i) begin
    if (push) mem_q[wr_q] <= wb.wb_dat_i[7:0];
  end
  // Line driven straight from state so an async reset returns it high at once.
  assign tx_o          = state_q == START ? 1'b0 : state_q == DATA ? sh_q[0] : 1'b1;
  assign irq_o         = irq_q;
  assign wb.wb_stall_o = 1'b0;
  assign wb.wb_ack_o   = ack_q;
  assign wb.wb_err_o   = err_q;
  assign wb.wb_dat_o   = dat_q;
endmodule

// File: tb/tb_uart_tx_wb.sv
// tb_uart_tx_wb: randomized bus traffic checked every cycle against a frame-level model
module tb_uart_tx_wb;
  localparam logic [31:0] BASE = 32'h0000_2020;
  logic clk = 1'b0, rst = 1'b0;
  bit started = 1'b0;
  int vectors = 0, miscompares = 0;
  logic tx_o, irq_o;
  uart_tx_wb_if bus();
  uart_tx_wb #(.BASE_ADR(BASE), .FIFO_DEPTH(8), .DIV_RESET(16'd433)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb(bus.slave), .tx_o(tx_o), .irq_o(irq_o));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic frame_bit(input logic [7:0] b, input int i);
    return i == 0 ? 1'b0 : i == 9 ? 1'b1 : b[i-1];
  endfunction
  logic [7:0]  mq[$];
  logic [7:0]  m_cur = '0;
  bit          m_act = 1'b0, m_full, m_empty, m_req, m_in, m_wtx, m_irqn;
  int          m_idx = 0, m_left = 0, m_pre;
  logic [15:0] m_div = 16'd433;
  logic [1:0]  m_ctrl = '0;
  logic        m_ack = 1'b0, m_err = 1'b0, m_irq = 1'b0;
  logic [31:0] m_dat = '0, m_off, m_rd;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_act = 1'b0; m_idx = 0; m_left = 0; m_div = 16'd433; m_ctrl = '0;
      m_ack = 1'b0; m_err = 1'b0; m_dat = '0; m_irq = 1'b0;
    end else begin
      m_pre   = mq.size();
      m_full  = m_pre == 8;
      m_empty = m_pre == 0;
      m_req   = bus.wb_cyc_i && bus.wb_stb_i;
      m_off   = bus.wb_adr_i - BASE;
      m_in    = m_off < 32'h10;
      m_wtx   = m_req && bus.wb_we_i && m_in && m_off[3:2] == 2'd0 && bus.wb_sel_i[0];
      m_err   = m_req && (!m_in || (m_wtx && m_full));
      m_ack   = m_req && !m_err;
      case (m_off[3:2])
        2'd1:    m_rd = {24'b0, 4'(m_pre), 1'b0, m_act, m_empty, m_full};
        2'd2:    m_rd = {16'b0, m_div};
        2'd3:    m_rd = {30'b0, m_ctrl};
        default: m_rd = '0;
      endcase
      m_dat  = (m_ack && !bus.wb_we_i) ? m_rd : '0;
      m_irqn = m_ctrl[1] && !m_act && m_empty;
      if (!m_act) begin
        if (m_ctrl[0] && !m_empty) begin
          m_cur = mq.pop_front(); m_act = 1'b1; m_idx = 0; m_left = int'(m_div);
        end
      end else if (m_left != 0) m_left--;
      else if (m_idx < 9) begin
        m_idx++; m_left = int'(m_div);
      end else if (m_ctrl[0] && !m_empty) begin
        m_cur = mq.pop_front(); m_idx = 0; m_left = int'(m_div);
      end else m_act = 1'b0;
      if (m_wtx && !m_full) mq.push_back(bus.wb_dat_i[7:0]);
      if (m_req && bus.wb_we_i && m_in && m_off[3:2] == 2'd2) begin
        if (bus.wb_sel_i[0]) m_div[7:0] = bus.wb_dat_i[7:0];
        if (bus.wb_sel_i[1]) m_div[15:8] = bus.wb_dat_i[15:8];
      end
      if (m_req && bus.wb_we_i && m_in && m_off[3:2] == 2'd3 && bus.wb_sel_i[0]) m_ctrl = bus.wb_dat_i[1:0];
      m_irq = m_irqn;
    end
  end
  always @(negedge clk) begin
    if (started) begin
      chk("tx_o",  32'(tx_o), 32'(m_act ? frame_bit(m_cur, m_idx) : 1'b1));
      chk("ack",   32'(bus.wb_ack_o), 32'(m_ack));
      chk("err",   32'(bus.wb_err_o), 32'(m_err));
      chk("dat",   bus.wb_dat_o, m_dat);
      chk("irq",   32'(irq_o), 32'(m_irq));
      chk("stall", 32'(bus.wb_stall_o), 32'd0);
    end
  end
  task automatic bus_idle();
    bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
    bus.wb_adr_i = '0; bus.wb_dat_i = '0; bus.wb_sel_i = '0;
  endtask
  task automatic drive(input logic we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = we;
    bus.wb_adr_i = a; bus.wb_dat_i = d; bus.wb_sel_i = s;
  endtask
  task automatic op(input logic we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                    output logic ack, output logic err, output logic [31:0] rd);
    drive(we, a, d, s);
    @(posedge clk); #1;
    ack = bus.wb_ack_o; err = bus.wb_err_o; rd = bus.wb_dat_o;
    bus_idle();
  endtask
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
  endtask
  task automatic do_reset();
    bus_idle();
    #2 rst = 1'b1;
    started = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
  endtask
  task automatic wait_low(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      if (tx_o === 1'b0) ok = 1'b1;
      else step(1);
    end
    chk(name, 32'(ok), 32'd1);
  endtask
  logic        a, e;
  logic [31:0] r;
  logic        samp [128];
  initial begin
    bus_idle();
    #1 do_reset();
    op(0, BASE + 32'h10, 0, 4'hF, a, e, r);
    chk("oor_ack", 32'(a), 0); chk("oor_err", 32'(e), 1); chk("oor_dat", r, 0);
    op(0, BASE + 32'h8, 0, 4'hF, a, e, r);
    chk("div_reset", r, 32'h0000_01B1);
    op(0, BASE + 32'h4, 0, 4'hF, a, e, r);
    chk("status_reset", r, 32'h02);
    op(1, BASE + 32'h8, 3, 4'h3, a, e, r);
    op(1, BASE + 32'hC, 1, 4'h1, a, e, r);
    op(1, BASE, 32'hA5, 4'h1, a, e, r);
    wait_low("a5_start");
    for (int t = 0; t < 40; t++) begin
      chk("a5_frame", 32'(tx_o), 32'(frame_bit(8'hA5, t / 4)));
      step(1);
    end
    chk("a5_idle", 32'(tx_o), 1);
    do_reset();
    for (int i = 0; i < 9; i++) begin
      op(1, BASE, 32'(i), 4'h1, a, e, r);
      chk("fill_ack", 32'(a), 32'(i < 8));
      chk("fill_err", 32'(e), 32'(i == 8));
    end
    op(0, BASE + 32'h4, 0, 4'hF, a, e, r);
    chk("status_full", r, 32'h81);
    do_reset();
    op(1, BASE + 32'h8, 3, 4'h3, a, e, r);
    op(1, BASE + 32'hC, 3, 4'h1, a, e, r);
    op(1, BASE, 32'h55, 4'h1, a, e, r);
    op(1, BASE, 32'hAA, 4'h1, a, e, r);
    wait_low("b2b_start");
    for (int t = 0; t < 82; t++) begin
      if (t < 80) chk("b2b_frame", 32'(tx_o), 32'(frame_bit(t < 40 ? 8'h55 : 8'hAA, (t % 40) / 4)));
      if (t == 40 || t == 80) chk("b2b_irq_low", 32'(irq_o), 0);
      if (t == 81) chk("b2b_irq_high", 32'(irq_o), 1);
      step(1);
    end
    do_reset();
    op(1, BASE + 32'h8, 3, 4'h3, a, e, r);
    op(1, BASE + 32'hC, 1, 4'h1, a, e, r);
    op(1, BASE, 32'h00, 4'h1, a, e, r);
    op(1, BASE, 32'h00, 4'h1, a, e, r);
    wait_low("rst_start");
    step(17);
    chk("rst_bit3_low", 32'(tx_o), 0);
    #2 rst = 1'b1;
    #1 chk("rst_tx_high", 32'(tx_o), 1);
    @(posedge clk); #1 rst = 1'b0;
    op(0, BASE + 32'h4, 0, 4'hF, a, e, r);
    chk("rst_status", r, 32'h02);
    do_reset();
    op(1, BASE + 32'h8, 3, 4'h3, a, e, r);
    op(1, BASE + 32'hC, 1, 4'h1, a, e, r);
    op(1, BASE, 32'h55, 4'h1, a, e, r);
    wait_low("div_start");
    for (int t = 0; t < 100; t++) begin
      samp[t] = tx_o;
      if (t == 13) drive(1, BASE + 32'h8, 7, 4'h3);
      if (t == 14) bus_idle();
      step(1);
    end
    chk("div_b1_end",  32'(samp[11]), 0);
    chk("div_b2_beg",  32'(samp[12]), 1);
    chk("div_b2_end",  32'(samp[15]), 1);
    chk("div_b3_beg",  32'(samp[16]), 0);
    chk("div_b3_end",  32'(samp[23]), 0);
    chk("div_b4_beg",  32'(samp[24]), 1);
    for (int seg = 0; seg < 6; seg++) begin
      if (seg == 3) do_reset();
      for (int c = 0; c < 700; c++) begin
        int k = $urandom_range(0, 9);
        bit busy_phase = c < 400;
        if ($urandom_range(0, 3) == 0 || (!busy_phase && k < 5)) begin
          bus_idle();
          bus.wb_cyc_i = 1'($urandom_range(0, 1));
        end else begin
          logic [3:0] s = 4'($urandom_range(0, 15));
          if (k < 5) drive(1, BASE, $urandom, s | 4'($urandom_range(0, 4) != 0));
          else if (k == 5) drive(1'($urandom_range(0, 1)), BASE + 32'h4, $urandom, s);
          else if (k == 6) drive(1'($urandom_range(0, 1)), BASE + 32'h8, 32'($urandom_range(0, 3)), s);
          else if (k == 7) drive(1'($urandom_range(0, 1)), BASE + 32'hC,
                                 32'($urandom_range(0, 4) == 0 ? 2 : $urandom_range(1, 3)), s);
          else if (k == 8) drive(0, BASE + 32'($urandom_range(0, 15)), $urandom, s);
          else drive(1'($urandom_range(0, 1)),
                     $urandom_range(0, 1) ? BASE + 32'h10 + 32'($urandom_range(0, 255)) : BASE - 32'h4,
                     $urandom, s);
        end
        step(1);
      end
      bus_idle();
    end
    step(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
